// File: rtl/serial_mag_comp_ctrl_pkg.sv
// cmp_pkg: shared FSM state type and comparator slice width for serial_mag_comp_ctrl
package cmp_pkg;
   typedef enum logic {IDLE, RUN} state_e;
   localparam int NIBBLE_W = 4;
endpackage

// File: rtl/serial_mag_comp_ctrl_if.sv
// serial_mag_comp_ctrl_if: request/result bundle between a requester and the serial comparator
interface serial_mag_comp_ctrl_if #(parameter int WIDTH = 16);
   localparam int NIB = WIDTH / 4;
   localparam int NCW = $clog2(NIB + 1);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             eq;
   logic             gt;
   logic             lt;
   logic [NCW-1:0]   ncmp;
   modport master (output start, a, b, input busy, done, eq, gt, lt, ncmp);
   modport slave  (input start, a, b, output busy, done, eq, gt, lt, ncmp);
endinterface

// File: rtl/serial_mag_comp_ctrl_nibble_comp.sv
// nibble_comp: 4-bit unsigned eq/gt/lt slice shared across all nibble positions
module nibble_comp
   import cmp_pkg::*;
(
   input  logic [NIBBLE_W-1:0] x,
   input  logic [NIBBLE_W-1:0] y,
   output logic                eq,
   output logic                gt,
   output logic                lt
);
   assign eq = x == y;
   assign gt = x > y;
   assign lt = x < y;
endmodule

// File: rtl/serial_mag_comp_ctrl.sv
// serial_mag_comp_ctrl: wide unsigned compare, one nibble per cycle MSB-first with early exit
module serial_mag_comp_ctrl
   import cmp_pkg::*;
#(
   parameter int WIDTH = 16
)(
   input  logic                 clk,
   input  logic                 rst_n,
   serial_mag_comp_ctrl_if.slave bus
);
   localparam int NIB = WIDTH / NIBBLE_W;
   localparam int IW  = NIB > 1 ? $clog2(NIB) : 1;
   localparam int NCW = $clog2(NIB + 1);
   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [NCW-1:0]   ncmp_q, ncmp_d;
   logic             done_q, done_d, eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
   logic             s_eq, s_gt, s_lt;
   nibble_comp u_slice (
      .x  (a_q[idx_q*NIBBLE_W +: NIBBLE_W]),
      .y  (b_q[idx_q*NIBBLE_W +: NIBBLE_W]),
      .eq (s_eq),
      .gt (s_gt),
      .lt (s_lt)
   );
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      ncmp_d  = ncmp_q;
      eq_d    = eq_q;
      gt_d    = gt_q;
      lt_d    = lt_q;
      done_d  = 1'b0;
      if (state_q == IDLE) begin
         if (bus.start) begin
            a_d     = bus.a;
            b_d     = bus.b;
            idx_d   = IW'(NIB - 1);
            ncmp_d  = '0;
            eq_d    = 1'b0;
            gt_d    = 1'b0;
            lt_d    = 1'b0;
            state_d = RUN;
         end
      end else begin
         ncmp_d = (ncmp_q == NCW'(NIB)) ? ncmp_q : ncmp_q + 1'b1;
         if (!s_eq) begin
            gt_d    = s_gt;
            lt_d    = s_lt;
            done_d  = 1'b1;
            state_d = IDLE;
         end else if (idx_q == '0) begin
            eq_d    = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
         end else begin
            idx_d = idx_q - 1'b1;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         ncmp_q  <= '0;
         done_q  <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         ncmp_q  <= ncmp_d;
         done_q  <= done_d;
         eq_q    <= eq_d;
         gt_q    <= gt_d;
         lt_q    <= lt_d;
      end
   end
   assign bus.busy = state_q == RUN;
   assign bus.done = done_q;
   assign bus.eq   = eq_q;
   assign bus.gt   = gt_q;
   assign bus.lt   = lt_q;
   assign bus.ncmp = ncmp_q;
endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// tb_serial_mag_comp_ctrl: directed scenarios for the serial comparator at WIDTH=16 and WIDTH=4
module tb_serial_mag_comp_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   always #5 clk = ~clk;
   serial_mag_comp_ctrl_if #(.WIDTH(16)) bus ();
   serial_mag_comp_ctrl_if #(.WIDTH(4))  bus4 ();
   serial_mag_comp_ctrl #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   serial_mag_comp_ctrl #(.WIDTH(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   // Issues one compare and returns how many cycles after the accepting edge done appeared (-1 on timeout).
   // Operands are scrambled right after acceptance so a result that tracks live inputs would be caught.
   task automatic do_cmp(input logic [15:0] av, input logic [15:0] bv, output int cyc);
      @(negedge clk);
      bus.start = 1'b1; bus.a = av; bus.b = bv;
      @(negedge clk);
      bus.start = 1'b0; bus.a = ~av; bus.b = ~bv;
      cyc = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.done) begin cyc = i; break; end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if ({bus.busy, bus.done, bus.eq, bus.gt, bus.lt} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b want=00000", {bus.busy, bus.done, bus.eq, bus.gt, bus.lt}); end
      checks++; if (bus.ncmp !== 3'd0) begin failures++; $display("FAIL reset_ncmp got=%0d want=0", bus.ncmp); end
      rst_n = 1'b1;
   endtask

   task automatic test_equal;
      int cyc;
      do_cmp(16'h1234, 16'h1234, cyc);
      checks++; if (cyc !== 4) begin failures++; $display("FAIL eq_latency got=%0d want=4", cyc); end
      checks++; if ({bus.eq, bus.gt, bus.lt} !== 3'b100) begin failures++; $display("FAIL eq_result got=%b want=100", {bus.eq, bus.gt, bus.lt}); end
      checks++; if (bus.ncmp !== 3'd4) begin failures++; $display("FAIL eq_ncmp got=%0d want=4", bus.ncmp); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL eq_busy_at_done got=%b want=0", bus.busy); end
      @(negedge clk);
      checks++; if ({bus.done, bus.eq, bus.ncmp} !== {1'b0, 1'b1, 3'd4}) begin failures++; $display("FAIL eq_hold got=%b want=01100", {bus.done, bus.eq, bus.ncmp}); end
   endtask

   task automatic test_gt_msb;
      int cyc;
      do_cmp(16'hA000, 16'h5FFF, cyc);
      checks++; if (cyc !== 1) begin failures++; $display("FAIL gt_msb_latency got=%0d want=1", cyc); end
      checks++; if ({bus.eq, bus.gt, bus.lt} !== 3'b010) begin failures++; $display("FAIL gt_msb_result got=%b want=010", {bus.eq, bus.gt, bus.lt}); end
      checks++; if (bus.ncmp !== 3'd1) begin failures++; $display("FAIL gt_msb_ncmp got=%0d want=1", bus.ncmp); end
   endtask

   task automatic test_lt_and_unsigned;
      int cyc;
      do_cmp(16'h12F3, 16'h12F4, cyc);
      checks++; if (cyc !== 4) begin failures++; $display("FAIL lt_latency got=%0d want=4", cyc); end
      checks++; if ({bus.eq, bus.gt, bus.lt} !== 3'b001) begin failures++; $display("FAIL lt_result got=%b want=001", {bus.eq, bus.gt, bus.lt}); end
      checks++; if (bus.ncmp !== 3'd4) begin failures++; $display("FAIL lt_ncmp got=%0d want=4", bus.ncmp); end
      do_cmp(16'hFFFF, 16'h0000, cyc);
      checks++; if (cyc !== 1) begin failures++; $display("FAIL unsigned_latency got=%0d want=1", cyc); end
      checks++; if ({bus.eq, bus.gt, bus.lt} !== 3'b010) begin failures++; $display("FAIL unsigned_result got=%b want=010", {bus.eq, bus.gt, bus.lt}); end
      do_cmp(16'h00FF, 16'h0100, cyc);
      checks++; if ({cyc, bus.lt, bus.ncmp} !== {32'd2, 1'b1, 3'd2}) begin failures++; $display("FAIL lt_nib2 cyc=%0d lt=%b ncmp=%0d want cyc=2 lt=1 ncmp=2", cyc, bus.lt, bus.ncmp); end
   endtask

   task automatic test_ignore_start;
      int cyc;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h1235;
      @(negedge clk);
      bus.start = 1'b0;
      checks++; if ({bus.busy, bus.eq, bus.gt, bus.lt} !== 4'b1000) begin failures++; $display("FAIL ign_running got=%b want=1000", {bus.busy, bus.eq, bus.gt, bus.lt}); end
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'h0000;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 2;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         cyc++;
         if (bus.done) break;
      end
      checks++; if (cyc !== 4) begin failures++; $display("FAIL ign_latency got=%0d want=4", cyc); end
      checks++; if ({bus.eq, bus.gt, bus.lt, bus.ncmp} !== {3'b001, 3'd4}) begin failures++; $display("FAIL ign_result got=%b want=001100", {bus.eq, bus.gt, bus.lt, bus.ncmp}); end
      @(negedge clk);
      checks++; if ({bus.busy, bus.done} !== 2'b00) begin failures++; $display("FAIL ign_no_extend got=%b want=00", {bus.busy, bus.done}); end
   endtask

   task automatic test_back_to_back;
      int cyc;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'hA000; bus.b = 16'h5FFF;
      @(negedge clk);
      bus.a = 16'h0010; bus.b = 16'h0001;
      @(negedge clk);
      checks++; if ({bus.done, bus.busy, bus.gt} !== 3'b101) begin failures++; $display("FAIL b2b_first got=%b want=101", {bus.done, bus.busy, bus.gt}); end
      @(negedge clk);
      bus.start = 1'b0;
      checks++; if ({bus.done, bus.busy, bus.gt, bus.ncmp} !== {3'b010, 3'd0}) begin failures++; $display("FAIL b2b_restart got=%b want=010000", {bus.done, bus.busy, bus.gt, bus.ncmp}); end
      cyc = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.done) begin cyc = i; break; end
      end
      checks++; if (cyc !== 3) begin failures++; $display("FAIL b2b_second_latency got=%0d want=3", cyc); end
      checks++; if ({bus.gt, bus.ncmp} !== {1'b1, 3'd3}) begin failures++; $display("FAIL b2b_second_result got=%b want=1011", {bus.gt, bus.ncmp}); end
   endtask

   task automatic test_reset_mid_run;
      int cyc;
      int seen;
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h1234;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if ({bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.ncmp} !== 8'b0) begin failures++; $display("FAIL rst_mid_outputs got=%b want=00000000", {bus.busy, bus.done, bus.eq, bus.gt, bus.lt, bus.ncmp}); end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.done || bus.busy) seen++;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL rst_mid_no_done got=%0d want=0", seen); end
      do_cmp(16'h8001, 16'h8002, cyc);
      checks++; if ({cyc, bus.lt, bus.ncmp} !== {32'd4, 1'b1, 3'd4}) begin failures++; $display("FAIL rst_mid_clean cyc=%0d lt=%b ncmp=%0d want cyc=4 lt=1 ncmp=4", cyc, bus.lt, bus.ncmp); end
   endtask

   task automatic test_width4;
      logic [3:0] av [2] = '{4'h9, 4'h3};
      logic [3:0] bv [2] = '{4'h9, 4'hC};
      logic [2:0] want [2] = '{3'b100, 3'b001};
      for (int k = 0; k < 2; k++) begin
         int cyc;
         @(negedge clk);
         bus4.start = 1'b1; bus4.a = av[k]; bus4.b = bv[k];
         @(negedge clk);
         bus4.start = 1'b0; bus4.a = ~av[k];
         checks++; if (bus4.busy !== 1'b1) begin failures++; $display("FAIL w4_busy_%0d got=%b want=1", k, bus4.busy); end
         cyc = -1;
         for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus4.done) begin cyc = i; break; end
         end
         checks++; if ({cyc, bus4.eq, bus4.gt, bus4.lt, bus4.ncmp} !== {32'd1, want[k], 1'b1}) begin failures++; $display("FAIL w4_cmp_%0d cyc=%0d res=%b ncmp=%0d want cyc=1 res=%b ncmp=1", k, cyc, {bus4.eq, bus4.gt, bus4.lt}, bus4.ncmp, want[k]); end
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.a = '0; bus.b = '0;
      bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
      test_reset;
      test_equal;
      test_gt_msb;
      test_lt_and_unsigned;
      test_ignore_start;
      test_back_to_back;
      test_reset_mid_run;
      test_width4;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
